// File: rtl/guess_ctrl_if.sv
// rtl/guess_ctrl_if.sv - keypad, Match and display signals of the guess-number sequencer
interface guess_ctrl_if;
  // keypad side
  logic       new_game;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_clr;
  logic       key_enter;
  // Match comparator side
  logic [2:0] r_a;
  logic [2:0] r_b;
  logic [3:0] q1, q2, q3, q4;
  logic [3:0] a1, a2, a3, a4;
  logic       match;
  // latched results and status for the display
  logic [2:0] res_a;
  logic [2:0] res_b;
  logic       res_valid;
  logic [3:0] tries;
  logic [2:0] pos;
  logic       err;
  logic       setting;
  logic       win;
  logic       lose;

  modport master (
    output new_game, key_valid, key_digit, key_clr, key_enter, r_a, r_b,
    input  q1, q2, q3, q4, a1, a2, a3, a4, match,
    input  res_a, res_b, res_valid, tries, pos, err, setting, win, lose
  );

  modport slave (
    input  new_game, key_valid, key_digit, key_clr, key_enter, r_a, r_b,
    output q1, q2, q3, q4, a1, a2, a3, a4, match,
    output res_a, res_b, res_valid, tries, pos, err, setting, win, lose
  );
endinterface

// File: rtl/guess_ctrl.sv
// rtl/guess_ctrl.sv - xAyB game sequencer: secret/guess entry, scoring handshake, win/lose
module guess_ctrl #(
  parameter int MAX_TRY = 8
) (
  input  logic       clk,
  input  logic       rst,
  guess_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    GUESS = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  state_t     state;
  logic [3:0] q [4];
  logic [3:0] a [4];
  logic [2:0] res_a, res_b;
  logic       res_valid, match, err, setting, win, lose;
  logic [3:0] tries;
  logic [2:0] pos;

  // the entry being edited: secret while in SET, guess otherwise
  logic [3:0] cur [4];
  logic       dup;
  logic       reject;
  logic [4:0] tries_next;

  // duplicate check only looks at digits already entered (index < pos),
  // so a stale guess from the previous round never blocks a new digit
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cur[i] = (state == SET) ? q[i] : a[i];
      if (3'(i) < pos && cur[i] == bus.key_digit) dup = 1'b1;
    end
    reject     = (bus.key_digit > 4'd9) || (pos == 3'd4) || dup;
    tries_next = {1'b0, tries} + 5'd1;
  end

  // single sequencer: state, entry registers, score latch and registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++) begin
        q[i] <= 4'd0;
        a[i] <= 4'd0;
      end
      res_a     <= 3'd0;
      res_b     <= 3'd0;
      res_valid <= 1'b0;
      match     <= 1'b0;
      err       <= 1'b0;
      setting   <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
      tries     <= 4'd0;
      pos       <= 3'd0;
    end else begin
      err       <= 1'b0;
      res_valid <= 1'b0;
      match     <= 1'b0;
      if (bus.new_game) begin
        state   <= SET;
        for (int i = 0; i < 4; i++) begin
          q[i] <= 4'd0;
          a[i] <= 4'd0;
        end
        res_a   <= 3'd0;
        res_b   <= 3'd0;
        tries   <= 4'd0;
        pos     <= 3'd0;
        setting <= 1'b1;
        win     <= 1'b0;
        lose    <= 1'b0;
      end else begin
        case (state)
          SET, GUESS: begin
            if (bus.key_clr) begin
              pos <= 3'd0;
              for (int i = 0; i < 4; i++) begin
                if (state == SET) q[i] <= 4'd0;
                else              a[i] <= 4'd0;
              end
            end else if (bus.key_enter) begin
              if (pos != 3'd4) begin
                err <= 1'b1;
              end else if (state == SET) begin
                state   <= GUESS;
                pos     <= 3'd0;
                setting <= 1'b0;
              end else begin
                state <= CHECK;
                match <= 1'b1;
              end
            end else if (bus.key_valid) begin
              if (reject) begin
                err <= 1'b1;
              end else begin
                // the first digit of an entry also wipes the rest, which is
                // how the previous guess is retired on the first keypress
                for (int i = 0; i < 4; i++) begin
                  if (3'(i) == pos || (pos == 3'd0 && i != 0)) begin
                    if (state == SET) q[i] <= (3'(i) == pos) ? bus.key_digit : 4'd0;
                    else              a[i] <= (3'(i) == pos) ? bus.key_digit : 4'd0;
                  end
                end
                pos <= pos + 3'd1;
              end
            end
          end
          CHECK: begin
            res_a     <= bus.r_a;
            res_b     <= bus.r_b;
            res_valid <= 1'b1;
            pos       <= 3'd0;
            if (tries_next <= 5'(MAX_TRY)) tries <= tries_next[3:0];
            if (bus.r_a == 3'd4) begin
              state <= WIN;
              win   <= 1'b1;
            end else if (tries_next >= 5'(MAX_TRY)) begin
              state <= LOSE;
              lose  <= 1'b1;
            end else begin
              state <= GUESS;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.q1        = q[0];
  assign bus.q2        = q[1];
  assign bus.q3        = q[2];
  assign bus.q4        = q[3];
  assign bus.a1        = a[0];
  assign bus.a2        = a[1];
  assign bus.a3        = a[2];
  assign bus.a4        = a[3];
  assign bus.match     = match;
  assign bus.res_a     = res_a;
  assign bus.res_b     = res_b;
  assign bus.res_valid = res_valid;
  assign bus.tries     = tries;
  assign bus.pos       = pos;
  assign bus.err       = err;
  assign bus.setting   = setting;
  assign bus.win       = win;
  assign bus.lose      = lose;

endmodule

// File: doc/guess_ctrl.md
# guess_ctrl

Game sequencer for the 4-digit guess-number (xAyB) design. It collects a secret and successive guesses from the keypad and enforces digit rules. Each complete guess is presented to the combinational Match comparator for exactly one cycle, and the block latches the A/B score, counts attempts and declares win or lose. It sits between the keypad decoder and the Match block; the display reads its latched outputs.

## Interface
- MAX_TRY, 8, number of guesses allowed per game (1..15)

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- new_game  input  1  one-cycle pulse: start a new game from any state
- key_valid  input  1  one-cycle pulse: key_digit holds a keypress
- key_digit  input  4  pressed digit; only 0..9 are legal
- key_clr  input  1  one-cycle pulse: discard the current partial entry
- key_enter  input  1  one-cycle pulse: submit the current entry
- r_a, r_b  input  3  score from Match (valid while match=1)
- q1..q4  output  4 each  secret digits, driven to Match
- a1..a4  output  4 each  guess digits, driven to Match
- match  output  1  compare enable to Match; high only in CHECK
- res_a, res_b  output  3 each  latched score of the last guess
- res_valid  output  1  one-cycle pulse: res_a/res_b updated
- tries  output  4  guesses scored this game
- pos  output  3  digits in the current entry (0..4)
- err  output  1  one-cycle pulse: an input was rejected
- setting, win, lose  output  1 each  state flags (SET, WIN, LOSE)

## Operation
- States: IDLE, SET, GUESS, CHECK, WIN, LOSE. Reset enters IDLE.
- new_game in any state goes to SET. It clears q1..q4, a1..a4, pos, tries, res_a and res_b. It overrides every other input in that cycle.
- Entry (SET writes q1..q4, GUESS writes a1..a4). The digit at index pos is written and pos increments.
- A key_valid is rejected with err=1 and no change if:
  - key_digit > 9;
  - pos = 4;
  - the digit equals a digit already in the current entry.
- Same-cycle priority: key_clr > key_enter > key_valid. The lower-priority inputs are ignored.
- key_clr sets pos=0 and zeros the current entry's digits. No err is raised.
- key_enter with pos<4 sets err=1 and makes no state change.
- key_enter with pos=4:
  - in SET: go to GUESS with pos=0;
  - in GUESS: go to CHECK.
- CHECK lasts exactly one cycle with match=1 and a1..a4/q1..q4 held stable. At that edge:
  - res_a<=r_a, res_b<=r_b, tries<=tries+1, pos<=0;
  - next state is WIN if r_a==4; otherwise LOSE if tries+1==MAX_TRY; otherwise GUESS.
- a1..a4 keep the last guess until the first key_valid or key_clr in GUESS. That first key_valid writes a1 and zeros a2..a4.
- In CHECK, WIN and LOSE, key inputs are ignored with no err. Only new_game leaves WIN/LOSE.
- In IDLE, key inputs are ignored with no err.
- tries saturates at MAX_TRY and never wraps.

## Timing
- Reset values: state IDLE; all outputs 0, including q*, a*, res_*, tries, pos, err, res_valid, match, setting, win and lose.
- All outputs are registered; a flag reflects the state it describes.
- A key_valid at edge n updates the entry and pos at edge n; err rises in the cycle after edge n.
- Guess path:
  - key_enter sampled at edge n puts the block in CHECK, so match=1 from edge n to edge n+1;
  - at edge n+1, res_* update, res_valid=1 for that cycle, and the next state is entered;
  - enter-to-result latency is 2 edges.
- rst asserted mid-CHECK drops match immediately and discards the result.
- Back-to-back key pulses on consecutive cycles are all accepted.

## Test plan
- Secret 1,2,3,4 entered, then enter; guess 1,2,4,3 entered, then enter -> match high for 1 cycle; res_a=2, res_b=2, res_valid pulse, tries=1, back in GUESS.
- Guess 1,2,3,4 -> res_a=4, res_b=0, win=1; further keys are ignored; new_game returns to SET with tries=0.
- MAX_TRY=2, two wrong guesses (5,6,7,8) -> second result res_a=0, res_b=0, tries=2, lose=1.
- Entry 3,3 -> second 3 rejected with err pulse and pos=1; key_digit=12 -> err, pos unchanged; fifth digit -> err; enter at pos=3 -> err, no CHECK.
- key_clr and key_valid in the same cycle at pos=2 -> pos=0 and the entry is zeroed.
- Async rst during CHECK -> match=0, outputs return to reset values and state is IDLE before the next edge.
